// File: rtl/hex_dec_display_decoder.sv
// ---------------------------------------------------------------------------
// hex_dec_display_decoder
//
// Reads back the eight seven-segment patterns shown by the hex/decimal display
// driver. It recovers the 8-bit value from the hex field (HEX7:HEX6) and the
// decimal field (HEX2..HEX0). It also flags malformed or inconsistent displays.
// One digit is examined per clock from a shadow copy taken at START.
//
// Ports
//   CLOCK_50   in   1   clock, rising edge
//   RESET      in   1   synchronous active-high reset
//   START      in   1   capture SEG_IN and begin a decode (only honoured in IDLE)
//   SEG_IN     in   56  {HEX7..HEX0}, 7 bits each, bit0=a .. bit6=g
//   BUSY       out  1   decode in progress (capture cycle through CHECK)
//   VALID      out  1   one-cycle pulse when VALUE/DEC_VALUE/ERR are final
//   VALUE      out  8   hex field value {HEX7,HEX6}
//   DEC_VALUE  out  10  decimal field value
//   ERR        out  4   [0] bad pattern [1] decimal>255 [2] hex!=dec [3] blank fault
// ---------------------------------------------------------------------------
module hex_dec_display_decoder #(
    parameter bit SEG_ACTIVE_LOW    = 1'b1,
    parameter bit DEC_LEADING_BLANK = 1'b1
) (
    input  logic        CLOCK_50,
    input  logic        RESET,
    input  logic        START,
    input  logic [55:0] SEG_IN,
    output logic        BUSY,
    output logic        VALID,
    output logic [7:0]  VALUE,
    output logic [9:0]  DEC_VALUE,
    output logic [3:0]  ERR
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SCAN  = 2'd1;
    localparam logic [1:0] S_CHECK = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]  state_q, state_d;
    logic [55:0] shadow_q, shadow_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  value_q, value_d;
    logic [9:0]  dec_q, dec_d;
    logic [3:0]  err_q, err_d;
    logic        nz_q, nz_d;     // a nonzero decimal digit has been seen

    // Returns {known, blank, value}; unknown patterns and blank give value 0.
    function automatic logic [5:0] seg_lookup(input logic [6:0] p);
        case (p)
            7'b1000000: seg_lookup = 6'b10_0000;
            7'b1111001: seg_lookup = 6'b10_0001;
            7'b0100100: seg_lookup = 6'b10_0010;
            7'b0110000: seg_lookup = 6'b10_0011;
            7'b0011001: seg_lookup = 6'b10_0100;
            7'b0010010: seg_lookup = 6'b10_0101;
            7'b0000010: seg_lookup = 6'b10_0110;
            7'b1111000: seg_lookup = 6'b10_0111;
            7'b0000000: seg_lookup = 6'b10_1000;
            7'b0010000: seg_lookup = 6'b10_1001;
            7'b0001000: seg_lookup = 6'b10_1010;
            7'b0000011: seg_lookup = 6'b10_1011;
            7'b1000110: seg_lookup = 6'b10_1100;
            7'b0100001: seg_lookup = 6'b10_1101;
            7'b0000110: seg_lookup = 6'b10_1110;
            7'b0001110: seg_lookup = 6'b10_1111;
            7'b1111111: seg_lookup = 6'b11_0000;
            default:    seg_lookup = 6'b00_0000;
        endcase
    endfunction

    logic [5:0] base;
    logic [6:0] raw, lit;
    logic       g_ok, g_blank;
    logic [3:0] g_val;
    logic [9:0] dec_x10;

    always_comb begin
        base = 6'({3'b000, idx_q}) * 6'd7;
        raw  = shadow_q[base +: 7];
        // Table is stored active-low; active-high panels are folded onto it.
        lit  = SEG_ACTIVE_LOW ? raw : ~raw;
        {g_ok, g_blank, g_val} = seg_lookup(lit);
        // acc*10 as acc*8 + acc*2, wrapping at 10 bits
        dec_x10 = 10'({dec_q, 3'b000}) + 10'({dec_q, 1'b0});
    end

    always_comb begin
        state_d  = state_q;
        shadow_d = shadow_q;
        idx_d    = idx_q;
        value_d  = value_q;
        dec_d    = dec_q;
        err_d    = err_q;
        nz_d     = nz_q;
        case (state_q)
            S_IDLE: begin
                if (START) begin
                    shadow_d = SEG_IN;
                    value_d  = '0;
                    dec_d    = '0;
                    err_d    = '0;
                    nz_d     = 1'b0;
                    idx_d    = 3'd7;
                    state_d  = S_SCAN;
                end
            end
            S_SCAN: begin
                case (idx_q)
                    3'd7, 3'd6: begin
                        if (g_blank)    err_d[3] = 1'b1;
                        else if (!g_ok) err_d[0] = 1'b1;
                        if (idx_q == 3'd7) value_d[7:4] = g_val;
                        else               value_d[3:0] = g_val;
                    end
                    3'd5, 3'd4, 3'd3: begin
                        if (!g_blank) err_d[3] = 1'b1;
                        if (!g_ok)    err_d[0] = 1'b1;
                    end
                    default: begin
                        // Blank and unknown glyphs contribute a 0 digit.
                        dec_d = dec_x10 + {6'b0, g_val};
                        if (!g_ok) begin
                            err_d[0] = 1'b1;
                        end else if (g_blank) begin
                            // Blank is only a leading zero, never in the ones place.
                            if (idx_q == 3'd0 || nz_q || !DEC_LEADING_BLANK)
                                err_d[3] = 1'b1;
                        end else begin
                            if (g_val > 4'd9)  err_d[0] = 1'b1;
                            if (g_val != 4'd0) nz_d = 1'b1;
                        end
                    end
                endcase
                if (idx_q == 3'd0) state_d = S_CHECK;
                else               idx_d   = idx_q - 3'd1;
            end
            S_CHECK: begin
                err_d[1] = err_q[1] | (dec_q > 10'd255);
                // A mismatch is meaningless once a glyph could not be read.
                err_d[2] = err_q[2] | (({2'b00, value_q} != dec_q) && !err_q[0]);
                state_d  = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state_q  <= S_IDLE;
            shadow_q <= '0;
            idx_q    <= '0;
            value_q  <= '0;
            dec_q    <= '0;
            err_q    <= '0;
            nz_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            idx_q    <= idx_d;
            value_q  <= value_d;
            dec_q    <= dec_d;
            err_q    <= err_d;
            nz_q     <= nz_d;
        end
    end

    // BUSY rises in the capture cycle itself, so with START held high it
    // only drops during DONE.
    assign BUSY      = (state_q == S_SCAN) || (state_q == S_CHECK) ||
                       ((state_q == S_IDLE) && START);
    assign VALID     = (state_q == S_DONE);
    assign VALUE     = value_q;
    assign DEC_VALUE = dec_q;
    assign ERR       = err_q;

endmodule

// File: tb/tb_hex_dec_display_decoder.sv
module tb_hex_dec_display_decoder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [55:0] seg = '0;
    logic        busy0, valid0, busy1, valid1;
    logic [7:0]  val0, val1;
    logic [9:0]  dec0, dec1;
    logic [3:0]  err0, err1;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int total = 0;
    int bad   = 0;

    hex_dec_display_decoder u0 (
        .CLOCK_50(clk), .RESET(rst), .START(start), .SEG_IN(seg),
        .BUSY(busy0), .VALID(valid0), .VALUE(val0), .DEC_VALUE(dec0), .ERR(err0)
    );

    hex_dec_display_decoder #(.DEC_LEADING_BLANK(1'b0)) u1 (
        .CLOCK_50(clk), .RESET(rst), .START(start), .SEG_IN(seg),
        .BUSY(busy1), .VALID(valid1), .VALUE(val1), .DEC_VALUE(dec1), .ERR(err1)
    );

    localparam int B = 16;   // blank glyph index
    localparam logic [6:0] PAT [17] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010,
        7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110, 7'b1111111 };

    typedef struct {
        logic [7:0] v;
        logic [9:0] d;
        logic [3:0] e;
        int         t;
    } exp_t;

    exp_t q0[$], q1[$];
    exp_t m0, m1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic int glyph(input logic [6:0] p);
        for (int i = 0; i < 17; i++) if (PAT[i] == p) return i;
        return -1;
    endfunction

    function automatic logic [55:0] mk(input int a7, a6, a5, a4, a3, a2, a1, a0);
        return {PAT[a7], PAT[a6], PAT[a5], PAT[a4], PAT[a3], PAT[a2], PAT[a1], PAT[a0]};
    endfunction

    function automatic exp_t ex(input int v, input int d, input int e);
        exp_t r;
        r.v = 8'(v); r.d = 10'(d); r.e = 4'(e); r.t = 0;
        return r;
    endfunction

    // Reference: read each glyph, then apply the display rules arithmetically.
    function automatic exp_t model(input logic [55:0] s, input bit lb);
        exp_t r;
        int   g[8];
        int   hv, acc, dg;
        bit   lead;
        r.e = '0; r.t = 0;
        hv = 0; acc = 0; lead = 1'b1;
        for (int i = 0; i < 8; i++) g[i] = glyph(s[i*7 +: 7]);
        for (int k = 7; k >= 6; k--) begin
            if (g[k] == B) r.e[3] = 1'b1;
            if (g[k] < 0)  r.e[0] = 1'b1;
            hv = hv * 16 + ((g[k] >= 0 && g[k] < 16) ? g[k] : 0);
        end
        for (int k = 5; k >= 3; k--) begin
            if (g[k] != B) r.e[3] = 1'b1;
            if (g[k] < 0)  r.e[0] = 1'b1;
        end
        for (int k = 2; k >= 0; k--) begin
            dg = 0;
            if (g[k] < 0) r.e[0] = 1'b1;
            else if (g[k] == B) begin
                if (k == 0 || !lead || !lb) r.e[3] = 1'b1;
            end else begin
                dg = g[k];
                if (dg > 9) r.e[0] = 1'b1;
                if (dg != 0) lead = 1'b0;
            end
            acc = (acc * 10 + dg) % 1024;
        end
        r.v = 8'(hv);
        r.d = 10'(acc);
        r.e[1] = (acc > 255);
        r.e[2] = (hv != acc) && !r.e[0];
        return r;
    endfunction

    // Monitors: pop and compare whenever a VALID pulse appears.
    always @(negedge clk) begin
        if (!rst && valid0) begin
            if (q0.size() == 0) chk("unexpected_valid_u0", 1, 0);
            else begin
                m0 = q0.pop_front();
                chk("value_u0", val0, m0.v);
                chk("dec_u0", dec0, m0.d);
                chk("err_u0", err0, m0.e);
                chk("latency_u0", cyc, m0.t);
                chk("busy_at_valid_u0", busy0, 0);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && valid1) begin
            if (q1.size() == 0) chk("unexpected_valid_u1", 1, 0);
            else begin
                m1 = q1.pop_front();
                chk("value_u1", val1, m1.v);
                chk("dec_u1", dec1, m1.d);
                chk("err_u1", err1, m1.e);
                chk("latency_u1", cyc, m1.t);
            end
        end
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while ((busy0 || valid0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("idle_wait_timeout", (n < 100), 1);
    endtask

    task automatic issue(input logic [55:0] s, input exp_t e0, input exp_t e1);
        wait_idle();
        seg = s;
        start = 1'b1;
        e0.t = cyc + 10;
        e1.t = cyc + 10;
        q0.push_back(e0);
        q1.push_back(e1);
        @(posedge clk);
        #1 start = 1'b0;
        seg = 56'({$urandom, $urandom});   // shadow copy must make this harmless
    endtask

    task automatic drain();
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("drain_pending", q0.size() + q1.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [55:0] s;
        int v, h, t, o, g2, g1, r, k, nv;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_value", val0, 0);
        chk("rst_dec", dec0, 0);
        chk("rst_err", err0, 0);
        chk("rst_busy", busy0, 0);
        chk("rst_valid", valid0, 0);
        rst = 1'b0;

        // Directed cases
        issue(mk(12, 8, B, B, B, 2, 0, 0), ex(8'hC8, 200, 0), ex(8'hC8, 200, 0));
        issue(mk(0, 0, B, B, B, B, B, 0), ex(0, 0, 0), ex(0, 0, 8));
        issue(mk(15, 15, B, B, B, 2, 5, 4), ex(255, 254, 4), ex(255, 254, 4));
        issue(mk(0, 0, B, B, B, 9, 9, 9), ex(0, 999, 6), ex(0, 999, 6));
        s = mk(12, 8, B, B, B, 2, 0, 0);
        s[34:28] = 7'b1010101;
        issue(s, ex(8'hC8, 200, 9), ex(8'hC8, 200, 9));
        issue(mk(0, 0, B, B, B, 0, 11, 0), ex(0, 110, 1), ex(0, 110, 1));
        issue(mk(0, 15, B, B, B, 1, B, 5), ex(15, 105, 12), ex(15, 105, 12));
        drain();

        // START re-pulsed and SEG_IN changed mid-decode
        wait_idle();
        seg = mk(12, 8, B, B, B, 2, 0, 0);
        start = 1'b1;
        m0 = ex(8'hC8, 200, 0); m0.t = cyc + 10;
        q0.push_back(m0); q1.push_back(m0);
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        seg = mk(1, 2, B, B, B, 0, 1, 8);
        drain();

        // RESET aborts a decode
        wait_idle();
        seg = mk(15, 15, B, B, B, 2, 5, 5);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_value", val0, 0);
        chk("abort_dec", dec0, 0);
        chk("abort_err", err0, 0);
        chk("abort_busy", busy0, 0);
        nv = 0;
        repeat (15) begin
            @(negedge clk);
            if (valid0 || valid1) nv++;
        end
        chk("abort_no_valid", nv, 0);
        issue(mk(6, 4, B, B, B, B, 9, 9), ex(100, 99, 4), ex(100, 99, 12));
        drain();

        // START held high for 30 cycles: back-to-back decodes
        wait_idle();
        s = mk(15, 15, B, B, B, 2, 5, 4);
        seg = s;
        start = 1'b1;
        for (int i = 0; i < 3; i++) begin
            m0 = ex(255, 254, 4);
            m0.t = cyc + 10 + 11 * i;
            q0.push_back(m0); q1.push_back(m0);
        end
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            chk("busy_low_only_done", busy0, !valid0);
        end
        start = 1'b0;
        drain();

        // Randomized displays, mostly well formed, some corrupted
        for (int n = 0; n < 40; n++) begin
            v = $urandom_range(0, 255);
            h = v / 100; t = (v / 10) % 10; o = v % 10;
            g2 = h; g1 = t;
            if ($urandom_range(0, 1) == 1 && h == 0) begin
                g2 = B;
                if (t == 0) g1 = B;
            end
            s = mk(v / 16, v % 16, B, B, B, g2, g1, o);
            r = $urandom_range(0, 3);
            if (r == 1) begin
                k = $urandom_range(0, 7);
                s[k*7 +: 7] = PAT[$urandom_range(0, 16)];
            end else if (r == 2) begin
                k = $urandom_range(0, 7);
                s[k*7 +: 7] = 7'($urandom);
            end else if (r == 3) begin
                k = $urandom_range(0, 2);
                s[k*7 +: 7] = PAT[$urandom_range(0, 9)];
            end
            issue(s, model(s, 1'b1), model(s, 1'b0));
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
